// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : MEM-stage direct-mapped, write-back, write-allocate data cache
//            controller with 32-byte lines and a slow 256-bit memory port.
// Revision : 1.0
// ============================================================================
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              MemStall_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [255:0]      mem_data_o
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - 5 - INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MISS       = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_READMISS   = 3'd3,
        S_READMISSOK = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [255:0]         r_data [NUM_LINES];

    logic [TAG_W-1:0]     r_req_tag;
    logic [INDEX_W-1:0]   r_req_idx;
    logic [255:0]         r_fill;

    logic [2:0]           w_off;
    logic [INDEX_W-1:0]   w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_req;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_hit;
    logic                 w_wr_hit;
    logic [31:0]          w_word;
    logic                 w_unused;

    assign w_off    = cpu_addr_i[4:2];
    assign w_idx    = cpu_addr_i[5+INDEX_W-1:5];
    assign w_tag    = cpu_addr_i[ADDR_W-1:5+INDEX_W];
    assign w_unused = ^cpu_addr_i[1:0];

    // A request with both strobes set is a store.
    assign w_req    = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_wr     = cpu_MemWrite_i;
    assign w_rd     = cpu_MemRead_i & ~cpu_MemWrite_i;
    assign w_hit    = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_wr_hit = (r_state == S_IDLE) & w_hit & w_wr;
    assign w_word   = r_data[w_idx][{w_off, 5'd0} +: 32];

    assign MemStall_o  = (r_state != S_IDLE) | (w_req & ~w_hit);
    assign cpu_rdata_o = ((r_state == S_IDLE) & w_hit & w_rd) ? w_word : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_dirty   <= '0;
            r_req_tag <= '0;
            r_req_idx <= '0;
            r_fill    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_hit) begin
                        r_req_tag <= w_tag;
                        r_req_idx <= w_idx;
                    end else if (w_wr_hit) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                S_READMISS: begin
                    if (mem_ack_i) begin
                        r_fill <= mem_data_i;
                    end
                end
                S_READMISSOK: begin
                    r_valid[r_req_idx] <= 1'b1;
                    r_dirty[r_req_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (w_wr_hit) begin
                r_data[w_idx][{w_off, 5'd0} +: 32] <= cpu_wdata_i;
            end else if (r_state == S_READMISSOK) begin
                r_data[r_req_idx] <= r_fill;
                r_tag[r_req_idx]  <= r_req_tag;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    w_next = S_MISS;
                end
            end
            S_MISS: begin
                if (r_valid[r_req_idx] && r_dirty[r_req_idx]) begin
                    w_next = S_WRITEBACK;
                end else begin
                    w_next = S_READMISS;
                end
            end
            S_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {r_tag[r_req_idx], r_req_idx, 5'd0};
                mem_data_o   = r_data[r_req_idx];
                if (mem_ack_i) begin
                    w_next = S_READMISS;
                end
            end
            S_READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {r_req_tag, r_req_idx, 5'd0};
                if (mem_ack_i) begin
                    w_next = S_READMISSOK;
                end
            end
            S_READMISSOK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Randomized self-checking bench for dcache_ctrl against a flat
//            word-memory reference plus a tag/valid/dirty occupancy model.
// Revision : 1.0
// ============================================================================
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_rdata_o;
    logic         MemStall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;

    dcache_ctrl #(.NUM_LINES(16), .ADDR_W(32)) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_wdata_i    (cpu_wdata_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_rdata_o    (cpu_rdata_o),
        .MemStall_o     (MemStall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Backing memory (per line) and the architecturally visible word values.
    logic [255:0] mem_store [int unsigned];
    logic [31:0]  gold      [int unsigned];

    // Occupancy model: only decides hit/miss/writeback, never data.
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [22:0]  m_tag   [16];

    int           lat_rd   = 2;
    int           lat_wb   = 2;
    bit           stray_en = 1'b0;
    int           n_rd     = 0;
    int           n_wb     = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [255:0] last_wb_data = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        int unsigned k;
        k = a >> 5;
        if (!mem_store.exists(k)) mem_store[k] = rand_line();
        return mem_store[k];
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        int unsigned  k;
        logic [255:0] l;
        k = a >> 2;
        if (gold.exists(k)) return gold[k];
        l = line_of(a);
        return l[{a[4:2], 5'd0} +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        gold.delete();
    endtask

    // Memory: acks in the Nth cycle enable is seen; stray acks while idle.
    initial begin
        int cnt;
        cnt        = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i  = 1'b0;
            mem_data_i = '0;
            if (mem_enable_o) begin
                cnt++;
                if (cnt >= (mem_write_o ? lat_wb : lat_rd)) begin
                    cnt       = 0;
                    mem_ack_i = 1'b1;
                    if (mem_write_o) begin
                        mem_store[mem_addr_o >> 5] = mem_data_o;
                        last_wb_addr = mem_addr_o;
                        last_wb_data = mem_data_o;
                        n_wb++;
                    end else begin
                        mem_data_i   = line_of(mem_addr_o);
                        last_rd_addr = mem_addr_o;
                        n_rd++;
                    end
                end
            end else begin
                cnt = 0;
                if (stray_en && $urandom_range(0, 3) == 0) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = rand_line();
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            chk("idle_outputs", {MemStall_o, mem_enable_o, mem_write_o, mem_addr_o, cpu_rdata_o}, '0);
            chk("idle_mem_data", mem_data_o, '0);
            @(posedge clk_i);
            #1;
        end
    endtask

    // Called and returns 1 time unit after a rising edge.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        logic [3:0]   ix;
        logic [22:0]  tg;
        bit           hit;
        bit           wb;
        bit           req;
        int           exp_stall;
        int           stalls;
        int           rd0;
        int           wb0;
        logic [31:0]  exp_rdata;
        logic [31:0]  vaddr;
        logic [255:0] vline;
        ix    = addr[8:5];
        tg    = addr[31:9];
        req   = rd | wr;
        hit   = req && m_valid[ix] && (m_tag[ix] == tg);
        wb    = req && !hit && m_valid[ix] && m_dirty[ix];
        vaddr = {m_tag[ix], ix, 5'd0};
        vline = '0;
        if (wb) begin
            for (int w = 0; w < 8; w++) vline[32*w +: 32] = gold_word(vaddr + 32'(4 * w));
        end
        exp_stall = (!req || hit) ? 0 : (3 + lat_rd + (wb ? lat_wb : 0));
        exp_rdata = (rd && !wr) ? gold_word(addr) : 32'h0;
        rd0 = n_rd;
        wb0 = n_wb;

        cpu_addr_i     = addr;
        cpu_wdata_i    = wd;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        stalls = 0;
        @(negedge clk_i);
        while (MemStall_o && stalls < 400) begin
            stalls++;
            @(negedge clk_i);
        end
        chk("stall_cycles", stalls, exp_stall);
        chk("rdata", cpu_rdata_o, exp_rdata);
        @(posedge clk_i);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;

        if (req && !hit) begin
            chk("read_requests", n_rd - rd0, 1);
            chk("read_addr", last_rd_addr, {addr[31:5], 5'd0});
            chk("wb_requests", n_wb - wb0, wb ? 1 : 0);
            if (wb) begin
                chk("wb_addr", last_wb_addr, vaddr);
                chk("wb_data", last_wb_data, vline);
            end
        end else begin
            chk("no_mem_traffic", (n_rd + n_wb) - (rd0 + wb0), 0);
        end

        if (req) begin
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            if (!hit) m_dirty[ix] = 1'b0;
            if (wr) begin
                m_dirty[ix]    = 1'b1;
                gold[addr >> 2] = wd;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] l;
        logic [31:0]  a;
        logic [22:0]  tags [4];
        int           seen;
        int           op;

        rst_i          = 1'b0;
        cpu_addr_i     = '0;
        cpu_wdata_i    = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Reset state, then a quiet bus.
        idle_cycles(5);

        // Cold load, ack in the 2nd enable cycle.
        l = rand_line();
        l[63:32] = 32'hDEADBEEF;
        mem_store[32'h400 >> 5] = l;
        lat_rd = 2;
        do_req(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        chk("cold_load_word", gold_word(32'h404), 32'hDEADBEEF);

        // Store hit, then load hit of the stored word.
        do_req(1'b0, 1'b1, 32'h0000_0408, 32'h1234_5678);
        do_req(1'b1, 1'b0, 32'h0000_0408, 32'h0);

        // Conflict miss on a dirty line forces a writeback first.
        lat_wb = 3;
        do_req(1'b1, 1'b0, 32'h0000_2408, 32'h0);
        chk("wb_word2", last_wb_data[95:64], 32'h1234_5678);

        // Shortest and long read latencies.
        lat_rd = 1;
        do_req(1'b1, 1'b0, 32'h0000_1040, 32'h0);
        lat_rd = 10;
        do_req(1'b1, 1'b0, 32'h0000_1060, 32'h0);

        // Reset while a read miss is outstanding.
        cpu_addr_i     = 32'h0000_3404;
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 60 && seen < 3; k++) begin
            @(negedge clk_i);
            if (mem_enable_o && !mem_write_o) seen++;
        end
        chk("readmiss_reached", seen, 3);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i         = 1'b1;
        cpu_MemRead_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        chk("rst_enable", mem_enable_o, 1'b0);
        chk("rst_bus", {mem_write_o, mem_addr_o, MemStall_o}, '0);
        @(posedge clk_i);
        #1;
        do_req(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        chk("reload_after_rst", gold_word(32'h404), 32'hDEADBEEF);

        // Randomized traffic with stray acks on an idle bus.
        tags[0] = 23'h000000;
        tags[1] = 23'h000001;
        tags[2] = 23'h7FFFFF;
        tags[3] = 23'h2AAAAA;
        stray_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            lat_rd = $urandom_range(1, 6);
            lat_wb = $urandom_range(1, 6);
            a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) idle_cycles(1);
            if (op < 5)       do_req(1'b1, 1'b0, a, 32'h0);
            else if (op < 9)  do_req(1'b0, 1'b1, a, $urandom);
            else              do_req(1'b1, 1'b1, a, $urandom);
        end

        // Read every touched word back through the cache.
        stray_en = 1'b0;
        lat_rd   = 2;
        lat_wb   = 2;
        foreach (gold[k]) begin
            do_req(1'b1, 1'b0, 32'(k) << 2, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
